// File: rtl/bindiv32b16b.sv
// ---------------------------------------------------------------------------
// bindiv32b16b -- sequential restoring divider, 32-bit dividend / 16-bit
// divisor -> 16-bit quotient + 16-bit remainder, one quotient bit per clock.
// It is the inverse of multiplier16b: for z = x*y with y != 0 it returns
// q = x, r = 0.
//
// Ports
//   clk        in   1  clock, all state changes on the rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  dividend/divisor present
//   in_ready   out  1  block can accept an operation (high only in IDLE)
//   z          in  32  dividend, sampled on the input handshake
//   y          in  16  divisor, sampled on the input handshake
//   out_valid  out  1  result valid, held until consumed
//   out_ready  in   1  consumer accepts the result
//   q          out 16  quotient
//   r          out 16  remainder
//   ovf        out  1  quotient does not fit in 16 bits (includes y == 0)
//   dbg_state  out  2  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the source keeps data stable while valid is high and not yet taken,
// and valid never waits on ready.
//
// Build option: define BINDIV_OVF_CHECK_EN to enable the overflow /
// zero-divisor check (one-cycle saturated result, ovf driven). Without it the
// check is removed, ovf is tied low and every operation runs 16 iterations.
// ---------------------------------------------------------------------------
module bindiv32b16b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] z,
  input  logic [15:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q,
  output logic [15:0] r,
  output logic        ovf,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;        // iteration counter, 15 down to 0
  logic [16:0] r_p;          // partial remainder
  logic [15:0] r_sh;         // remaining dividend bits, MSB consumed first
  logic [15:0] r_quo;        // quotient bits collected so far
  logic [15:0] r_y;          // latched divisor
  logic [15:0] r_q;
  logic [15:0] r_r;
  logic        r_in_ready;
  logic        r_out_valid;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. r_p stays below r_y, so
  // bit 16 of the shifted value only matters for the compare.
  logic [17:0] w_t;
  logic        w_ge;
  logic [16:0] w_diff;
  logic [16:0] w_p_next;
  logic        w_qbit;

  always_comb begin
    w_t      = {r_p, r_sh[15]};
    w_ge     = (w_t >= {2'b00, r_y});
    w_diff   = w_t[16:0] - {1'b0, r_y};
    w_p_next = w_ge ? w_diff : w_t[16:0];
    w_qbit   = w_ge;
  end

`ifdef BINDIV_OVF_CHECK_EN
  logic r_ovf;
  // Quotient would need more than 16 bits when the upper dividend half is
  // not below the divisor; y == 0 always lands here.
  logic w_ovf_in;
  assign w_ovf_in = (z[31:16] >= y);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_p         <= 17'd0;
      r_sh        <= 16'd0;
      r_quo       <= 16'd0;
      r_y         <= 16'd0;
      r_q         <= 16'd0;
      r_r         <= 16'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef BINDIV_OVF_CHECK_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is the
          // handshake here.
          if (in_valid) begin
            r_y        <= y;
            r_quo      <= 16'd0;
            r_in_ready <= 1'b0;
`ifdef BINDIV_OVF_CHECK_EN
            if (w_ovf_in) begin
              r_p         <= 17'd0;
              r_q         <= 16'hFFFF;
              r_r         <= 16'h0000;
              r_ovf       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
`else
            begin
`endif
              r_p     <= {1'b0, z[31:16]};
              r_sh    <= z[15:0];
              r_cnt   <= 4'd15;
              r_state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          r_p   <= w_p_next;
          r_quo <= {r_quo[14:0], w_qbit};
          r_sh  <= {r_sh[14:0], 1'b0};
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd0) begin
            r_q         <= {r_quo[14:0], w_qbit};
            r_r         <= w_p_next[15:0];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef BINDIV_OVF_CHECK_EN
            r_ovf       <= 1'b0;
`endif
          end
        end

        S_DONE: begin
          // Result stays put until taken; new input is not accepted in the
          // same cycle because in_ready is low here.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign q         = r_q;
  assign r         = r_r;
  assign dbg_state = r_state;
`ifdef BINDIV_OVF_CHECK_EN
  assign ovf       = r_ovf;
`else
  assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_bindiv32b16b.sv
`timescale 1ns/1ps
module tb_bindiv32b16b;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] z;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic [15:0] r;
  logic        ovf;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  bindiv32b16b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Present one operation, wait for acceptance, then count edges after the
  // accept edge until out_valid is seen (0 = visible right after accept).
  // The result is left pending (out_ready low).
  task automatic run_op(input logic [31:0] tz, input logic [15:0] ty,
                        output int lat, output bit to);
    int n;
    to  = 1'b0;
    lat = 0;
    n   = 0;
    @(negedge clk);
    out_ready = 1'b0;
    z = tz; y = ty; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      to = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) to = 1'b1;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; z = '0; y = '0;
    #23;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%b want=0", out_valid); end
    total++; if (q !== 16'h0) begin bad++; $display("FAIL reset_q: got=%h want=0000", q); end
    total++; if (r !== 16'h0) begin bad++; $display("FAIL reset_r: got=%h want=0000", r); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got=%b want=0", ovf); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got=%0d want=0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_divide();
    logic [31:0] vz [6];
    logic [15:0] vy [6];
    logic [15:0] vq [6];
    logic [15:0] vr [6];
    int lat;
    bit to;
    vz[0] = 32'hA6144983; vy[0] = 16'hBEEF; vq[0] = 16'hDEAD; vr[0] = 16'h0000;
    vz[1] = 32'd100;      vy[1] = 16'd7;    vq[1] = 16'd14;   vr[1] = 16'd2;
    vz[2] = 32'hFFFE0001; vy[2] = 16'hFFFF; vq[2] = 16'hFFFF; vr[2] = 16'h0000;
    vz[3] = 32'd0;        vy[3] = 16'd5;    vq[3] = 16'd0;    vr[3] = 16'd0;
    vz[4] = 32'h0000FFFF; vy[4] = 16'h0001; vq[4] = 16'hFFFF; vr[4] = 16'h0000;
    vz[5] = 32'h12345678; vy[5] = 16'hABCD; vq[5] = 16'h1B20; vr[5] = 16'h3DD8;
    for (int i = 0; i < 6; i++) begin
      run_op(vz[i], vy[i], lat, to);
      total++; if (to) begin bad++; $display("FAIL div%0d_timeout: got=timeout want=result", i); end
      total++; if (lat != 16) begin bad++; $display("FAIL div%0d_latency: got=%0d want=16", i, lat); end
      total++; if (q !== vq[i]) begin bad++; $display("FAIL div%0d_q: got=%h want=%h", i, q, vq[i]); end
      total++; if (r !== vr[i]) begin bad++; $display("FAIL div%0d_r: got=%h want=%h", i, r, vr[i]); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL div%0d_ovf: got=%b want=0", i, ovf); end
      consume();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++; $display("FAIL div%0d_release: got in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    bit to;
    run_op(32'hA6144988, 16'hBEEF, lat, to);
    total++; if (to) begin bad++; $display("FAIL hold_timeout: got=timeout want=result"); end
    // Unrelated input presented while the result waits must be ignored.
    @(negedge clk);
    z = 32'd100; y = 16'd7; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c%0d: got=%b want=1", c, out_valid); end
      total++; if (q !== 16'hDEAD) begin bad++; $display("FAIL hold_q c%0d: got=%h want=dead", c, q); end
      total++; if (r !== 16'h0005) begin bad++; $display("FAIL hold_r c%0d: got=%h want=0005", c, r); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready c%0d: got=%b want=0", c, in_ready); end
    end
    in_valid = 1'b0;
    consume();
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL hold_idle: got=%0d want=0", dbg_state); end
  endtask

`ifdef BINDIV_OVF_CHECK_EN
  task automatic test_overflow();
    int lat;
    bit to;
    logic [31:0] oz [2];
    logic [15:0] oy [2];
    oz[0] = 32'h00010000; oy[0] = 16'h0001;
    oz[1] = 32'h12345678; oy[1] = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      run_op(oz[i], oy[i], lat, to);
      total++; if (to) begin bad++; $display("FAIL ovf%0d_timeout: got=timeout want=result", i); end
      total++; if (lat != 0) begin bad++; $display("FAIL ovf%0d_latency: got=%0d want=0", i, lat); end
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf%0d_flag: got=%b want=1", i, ovf); end
      total++; if (q !== 16'hFFFF) begin bad++; $display("FAIL ovf%0d_q: got=%h want=ffff", i, q); end
      total++; if (r !== 16'h0000) begin bad++; $display("FAIL ovf%0d_r: got=%h want=0000", i, r); end
      consume();
    end
  endtask
`endif

  task automatic test_back_to_back();
    int cyc, n_acc, n_res;
    int acc_cyc [2];
    int res_cyc [2];
    logic [15:0] got_q [2];
    logic [15:0] got_r [2];
    cyc = 0; n_acc = 0; n_res = 0;
    @(negedge clk);
    out_ready = 1'b1;
    z = 32'd100; y = 16'd7; in_valid = 1'b1;
    // Each negedge looks at the handshakes that will fire on the next edge.
    while (n_res < 2 && cyc < 200) begin
      cyc++;
      if (in_valid && in_ready) begin
        if (n_acc < 2) acc_cyc[n_acc] = cyc;
        n_acc++;
      end else if (n_acc == 1) begin
        z = 32'd1000; y = 16'd3;
      end else if (n_acc >= 2) begin
        in_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        got_q[n_res] = q; got_r[n_res] = r; res_cyc[n_res] = cyc;
        n_res++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (n_res != 2 || n_acc != 2) begin
      bad++; $display("FAIL b2b_count: got acc=%0d res=%0d want 2/2", n_acc, n_res);
    end else begin
      total++; if (acc_cyc[1] != res_cyc[0] + 1) begin bad++; $display("FAIL b2b_accept_gap: got=%0d want=1", acc_cyc[1] - res_cyc[0]); end
      total++; if (res_cyc[0] != acc_cyc[0] + 17) begin bad++; $display("FAIL b2b_first_latency: got=%0d want=17", res_cyc[0] - acc_cyc[0]); end
      total++; if (got_q[0] !== 16'd14 || got_r[0] !== 16'd2) begin bad++; $display("FAIL b2b_res0: got q=%h r=%h want 000e/0002", got_q[0], got_r[0]); end
      total++; if (got_q[1] !== 16'd333 || got_r[1] !== 16'd1) begin bad++; $display("FAIL b2b_res1: got q=%h r=%h want 014d/0001", got_q[1], got_r[1]); end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit to;
    bit seen;
    @(negedge clk);
    z = 32'hA6144983; y = 16'hBEEF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL rst_run_entered: got=%0d want=1", dbg_state); end
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_handshake: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    total++; if (q !== 16'h0 || r !== 16'h0 || ovf !== 1'b0) begin
      bad++; $display("FAIL rst_mid_outputs: got q=%h r=%h ovf=%b want 0/0/0", q, r, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL rst_aborted_valid: got=1 want=0"); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_idle: got=%0d want=0", dbg_state); end
    run_op(32'd5000, 16'd70, lat, to);
    total++; if (to || q !== 16'd71 || r !== 16'd30) begin
      bad++; $display("FAIL rst_next_op: got q=%h r=%h to=%b want 0047/001e/0", q, r, to);
    end
    consume();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_divide();
    test_hold();
`ifdef BINDIV_OVF_CHECK_EN
    test_overflow();
`endif
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
